// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Serial front end of the UART receive path. rx_i is synchronised, a start
//   bit is qualified at mid-bit, then every data/parity/stop bit is sampled at
//   mid-period using a runtime clocks-per-bit divider. Each completed frame
//   updates dout_o; good frames raise a single-cycle rx_done_tick_o.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   : start + DATA_BITS + parity + stop, parity_odd_i selects odd/even
//     undefined : start + DATA_BITS + stop, parity_err_o stays 0
module uart_rx_sampler #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 rx_i,
    input  logic [15:0]          baud_div,
    input  logic                 parity_odd_i,
    output logic [DATA_BITS-1:0] dout_o,
    output logic                 rx_done_tick_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 busy_o
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser; flops come out of reset high (idle line) so a
    // reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxs;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            // One synchroniser stage: stage 0 takes the raw line, others chain.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    sync_reg[gi] <= 1'b1;
                end else if (gi == 0) begin
                    sync_reg[gi] <= rx_i;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    assign rxs = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM and datapath state
    // ------------------------------------------------------------------
    state_t                 state_reg, state_next;
    logic [15:0]            cnt_reg, cnt_next;
    logic [15:0]            div_reg, div_next;
    logic [2:0]             idx_reg, idx_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [DATA_BITS-1:0]   dout_reg, dout_next;
    logic                   par_bad_reg, par_bad_next;
    logic                   done_reg, done_next;
    logic                   ferr_reg, ferr_next;
    logic                   perr_reg, perr_next;

    logic [15:0]            half_m1;
    logic                   bit_end;

    // Start bit is checked half a bit in; every later bit one full bit apart.
    assign half_m1 = (div_reg >> 1) - 16'd1;
    assign bit_end = (cnt_reg == div_reg - 16'd1);

`ifndef UART_RX_PARITY_EN
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd_i;
`endif

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            div_reg     <= '0;
            idx_reg     <= '0;
            shift_reg   <= '0;
            dout_reg    <= '0;
            par_bad_reg <= 1'b0;
            done_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            perr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            div_reg     <= div_next;
            idx_reg     <= idx_next;
            shift_reg   <= shift_next;
            dout_reg    <= dout_next;
            par_bad_reg <= par_bad_next;
            done_reg    <= done_next;
            ferr_reg    <= ferr_next;
            perr_reg    <= perr_next;
        end
    end

    // Next-state, bit sampling and pulse generation.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        div_next     = div_reg;
        idx_next     = idx_reg;
        shift_next   = shift_reg;
        dout_next    = dout_reg;
        par_bad_next = par_bad_reg;
        done_next    = 1'b0;
        ferr_next    = 1'b0;
        perr_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                // Dividers below 4 leave no room for a mid-bit sample.
                if (!rxs && (baud_div >= 16'd4)) begin
                    state_next   = START;
                    div_next     = baud_div;
                    par_bad_next = 1'b0;
                end
            end

            START: begin
                if (cnt_reg == half_m1) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    // A line that is high again mid-start was only a glitch.
                    state_next = rxs ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    // LSB arrives first, so new bits enter at the top.
                    shift_next = {rxs, shift_reg[DATA_BITS-1:1]};
                    idx_next   = idx_reg + 3'd1;
                    if (idx_reg == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_next     = '0;
                    // XOR of data and parity bit must equal 1 for odd, 0 for even.
                    par_bad_next = ((^shift_reg) ^ rxs) != parity_odd_i;
                    state_next   = STOP;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    cnt_next  = '0;
                    dout_next = shift_reg;
`ifdef UART_RX_PARITY_EN
                    perr_next = par_bad_reg;
`endif
                    if (rxs) begin
                        done_next  = !par_bad_reg;
                        state_next = IDLE;
                    end else begin
                        // Low stop bit: wait for the line to recover before
                        // hunting for another start edge.
                        ferr_next  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            WAIT_IDLE: begin
                cnt_next = '0;
                if (rxs) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign dout_o         = dout_reg;
    assign rx_done_tick_o = done_reg;
    assign frame_err_o    = ferr_reg;
    assign parity_err_o   = perr_reg;
    assign busy_o         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler
//   Directed bench for uart_rx_sampler: reset state, clean frame, start
//   glitch, framing error with stuck-low line, back-to-back frames, reset
//   mid-frame, tiny divider, and (with UART_RX_PARITY_EN) parity checking.
module tb_uart_rx_sampler;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        rx_i = 1'b1;
    logic [15:0] baud_div = 16'd16;
    logic        parity_odd_i = 1'b1;
    logic [7:0]  dout_o;
    logic        rx_done_tick_o;
    logic        frame_err_o;
    logic        parity_err_o;
    logic        busy_o;

    int tests_run = 0;
    int tests_failed = 0;

    // Pulse monitors (only this block writes these)
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         busy_cnt = 0;
    int         dbl_cnt = 0;
    logic       prev_done = 1'b0;
    logic [7:0] dout_log [0:63];

    always #5 clk_i = ~clk_i;

    uart_rx_sampler #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .rx_i           (rx_i),
        .baud_div       (baud_div),
        .parity_odd_i   (parity_odd_i),
        .dout_o         (dout_o),
        .rx_done_tick_o (rx_done_tick_o),
        .frame_err_o    (frame_err_o),
        .parity_err_o   (parity_err_o),
        .busy_o         (busy_o)
    );

    // Sample outputs on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (rx_done_tick_o) begin
            if (done_cnt < 64) dout_log[done_cnt] = dout_o;
            done_cnt = done_cnt + 1;
            if (prev_done) dbl_cnt = dbl_cnt + 1;
        end
        prev_done = rx_done_tick_o;
        if (frame_err_o)  ferr_cnt = ferr_cnt + 1;
        if (parity_err_o) perr_cnt = perr_cnt + 1;
        if (busy_o)       busy_cnt = busy_cnt + 1;
    end

    // Drive one full frame, bit by bit, div cycles per bit.
    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stop_bit, input int div);
        $display("[TB] frame data=0x%02h par=%0b stop=%0b div=%0d", d, par, stop_bit, div);
        rx_i = 1'b0;
        repeat (div) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (div) @(negedge clk_i);
        end
`ifdef UART_RX_PARITY_EN
        rx_i = par;
        repeat (div) @(negedge clk_i);
`endif
        rx_i = stop_bit;
        repeat (div) @(negedge clk_i);
    endtask

    task automatic test_reset;
        rstn_i = 1'b0;
        rx_i   = 1'b1;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (3) @(negedge clk_i);
        tests_run++;
        if (dout_o !== 8'h00) begin tests_failed++; $display("FAIL reset_dout got=0x%02h exp=0x00", dout_o); end
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        tests_run++;
        if (rx_done_tick_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%0b exp=0", rx_done_tick_o); end
        tests_run++;
        if (frame_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr got=%0b exp=0", frame_err_o); end
        tests_run++;
        if (parity_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_perr got=%0b exp=0", parity_err_o); end
    endtask

    task automatic test_basic_frame;
        int d0, f0, p0;
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        baud_div = 16'd16;
        send_frame(8'hA5, (^8'hA5) ^ parity_odd_i, 1'b1, 16);
        repeat (20) @(negedge clk_i);
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL basic_ticks got=%0d exp=1", done_cnt - d0); end
        tests_run++;
        if (dout_o !== 8'hA5) begin tests_failed++; $display("FAIL basic_dout got=0x%02h exp=0xa5", dout_o); end
        tests_run++;
        if ((ferr_cnt - f0) + (perr_cnt - p0) !== 0) begin
            tests_failed++; $display("FAIL basic_errs got=%0d exp=0", (ferr_cnt - f0) + (perr_cnt - p0));
        end
        tests_run++;
        if (dbl_cnt !== 0) begin tests_failed++; $display("FAIL basic_single_tick got=%0d exp=0", dbl_cnt); end
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL basic_idle_busy got=%0b exp=0", busy_o); end
    endtask

    task automatic test_glitch;
        int d0, b0, waited;
        d0 = done_cnt; b0 = busy_cnt;
        $display("[TB] glitch low 4 cycles div=16");
        rx_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rx_i = 1'b1;
        waited = 0;
        while (busy_o === 1'b1 || waited == 0) begin
            @(negedge clk_i);
            waited++;
            if (waited > 8 + 2) break;
        end
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_timeout got=%0b exp=0", busy_o); end
        tests_run++;
        if (busy_cnt - b0 == 0) begin tests_failed++; $display("FAIL glitch_busy_seen got=0 exp=>0"); end
        repeat (20) @(negedge clk_i);
        tests_run++;
        if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL glitch_ticks got=%0d exp=0", done_cnt - d0); end
    endtask

    task automatic test_frame_error;
        int d0, f0, waited;
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, (^8'h3C) ^ parity_odd_i, 1'b0, 16);
        repeat (40) @(negedge clk_i);
        tests_run++;
        if (ferr_cnt - f0 !== 1) begin tests_failed++; $display("FAIL ferr_pulse got=%0d exp=1", ferr_cnt - f0); end
        tests_run++;
        if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL ferr_no_tick got=%0d exp=0", done_cnt - d0); end
        tests_run++;
        if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL ferr_busy_stuck got=%0b exp=1", busy_o); end
        tests_run++;
        if (dout_o !== 8'h3C) begin tests_failed++; $display("FAIL ferr_dout got=0x%02h exp=0x3c", dout_o); end
        rx_i = 1'b1;
        waited = 0;
        while (busy_o === 1'b1 && waited < 8 + 2) begin
            @(negedge clk_i);
            waited++;
        end
        tests_run++;
        if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL ferr_recover got=%0b exp=0", busy_o); end
        repeat (16) @(negedge clk_i);
        d0 = done_cnt;
        send_frame(8'h11, (^8'h11) ^ parity_odd_i, 1'b1, 16);
        repeat (20) @(negedge clk_i);
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL ferr_next_tick got=%0d exp=1", done_cnt - d0); end
        tests_run++;
        if (dout_o !== 8'h11) begin tests_failed++; $display("FAIL ferr_next_dout got=0x%02h exp=0x11", dout_o); end
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = done_cnt;
        baud_div = 16'd10;
        send_frame(8'h00, (^8'h00) ^ parity_odd_i, 1'b1, 10);
        send_frame(8'hFF, (^8'hFF) ^ parity_odd_i, 1'b1, 10);
        repeat (20) @(negedge clk_i);
        tests_run++;
        if (done_cnt - d0 !== 2) begin tests_failed++; $display("FAIL b2b_ticks got=%0d exp=2", done_cnt - d0); end
        else begin
            tests_run++;
            if (dout_log[d0] !== 8'h00) begin tests_failed++; $display("FAIL b2b_first got=0x%02h exp=0x00", dout_log[d0]); end
            tests_run++;
            if (dout_log[d0+1] !== 8'hFF) begin tests_failed++; $display("FAIL b2b_second got=0x%02h exp=0xff", dout_log[d0+1]); end
        end
        tests_run++;
        if (dbl_cnt !== 0) begin tests_failed++; $display("FAIL b2b_single_tick got=%0d exp=0", dbl_cnt); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        int d0;
        d = 8'h5A;
        baud_div = 16'd16;
        $display("[TB] frame data=0x5a aborted by reset in bit 4");
        rx_i = 1'b0;
        repeat (16) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            rx_i = d[i];
            repeat (16) @(negedge clk_i);
        end
        rx_i = d[4];
        repeat (8) @(negedge clk_i);
        tests_run++;
        if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy_before got=%0b exp=1", busy_o); end
        rstn_i = 1'b0;
        #1;
        tests_run++;
        if (busy_o !== 1'b0 || dout_o !== 8'h00 || rx_done_tick_o !== 1'b0 || frame_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs got busy=%0b dout=0x%02h done=%0b ferr=%0b exp all 0",
                     busy_o, dout_o, rx_done_tick_o, frame_err_o);
        end
        rx_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (4) @(negedge clk_i);
        d0 = done_cnt;
        send_frame(8'h5A, (^8'h5A) ^ parity_odd_i, 1'b1, 16);
        repeat (20) @(negedge clk_i);
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL rstmid_ticks got=%0d exp=1", done_cnt - d0); end
        tests_run++;
        if (dout_o !== 8'h5A) begin tests_failed++; $display("FAIL rstmid_dout got=0x%02h exp=0x5a", dout_o); end
    endtask

    task automatic test_small_divider;
        int d0, b0;
        d0 = done_cnt; b0 = busy_cnt;
        baud_div = 16'd3;
        send_frame(8'h81, (^8'h81) ^ parity_odd_i, 1'b1, 3);
        repeat (10) @(negedge clk_i);
        tests_run++;
        if (busy_cnt - b0 !== 0) begin tests_failed++; $display("FAIL smalldiv_busy got=%0d exp=0", busy_cnt - b0); end
        tests_run++;
        if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL smalldiv_ticks got=%0d exp=0", done_cnt - d0); end
        baud_div = 16'd16;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int d0, p0;
        parity_odd_i = 1'b1;
        baud_div = 16'd16;
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b0, 1'b1, 16);
        repeat (20) @(negedge clk_i);
        tests_run++;
        if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL parity_good_tick got=%0d exp=1", done_cnt - d0); end
        tests_run++;
        if (perr_cnt - p0 !== 0) begin tests_failed++; $display("FAIL parity_good_perr got=%0d exp=0", perr_cnt - p0); end
        d0 = done_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 16);
        repeat (20) @(negedge clk_i);
        tests_run++;
        if (perr_cnt - p0 !== 1) begin tests_failed++; $display("FAIL parity_bad_perr got=%0d exp=1", perr_cnt - p0); end
        tests_run++;
        if (done_cnt - d0 !== 0) begin tests_failed++; $display("FAIL parity_bad_tick got=%0d exp=0", done_cnt - d0); end
    endtask
`endif

    initial begin
        @(negedge clk_i);
        test_reset;
        test_basic_frame;
        test_glitch;
        test_frame_error;
        test_back_to_back;
        test_reset_mid_frame;
        test_small_divider;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout sim_time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule
